input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Conditions one raw asynchronous input (pin/switch) into a clean, glitch-free level for
//   the registered capture stage directly downstream; level_out drives that stage's data input.
//   Synchronizes raw_in, requires DEBOUNCE_CYCLES consecutive equal samples before committing
//   a change, emits one-cycle edge pulses, and counts committed rising edges.
// PARAMETERS
//   SYNC_STAGES      2    synchronizer flops on raw_in (>=2)
//   DEBOUNCE_CYCLES  16   consecutive identical synchronized samples needed to commit (>=1)
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, localparam)
//   EVT_W            8    width of rising-edge event counter (>=1)
// PORTS
//   clk         input   1      single clock; all state on posedge clk
//   reset       input   1      asynchronous, active-high reset
//   raw_in      input   1      unsynchronized raw signal
//   clr_evt     input   1      synchronous clear of evt_count
//   level_out   output  1      debounced level (feeds capture stage data input)
//   rise_pulse  output  1      one-cycle pulse on committed 0->1
//   fall_pulse  output  1      one-cycle pulse on committed 1->0
//   stable      output  1      1 when FSM is in a *_STABLE state
//   evt_count   output  EVT_W  saturating count of committed rising edges
// BEHAVIOUR
//   - Reset (async, active-high): sync chain 0, state LOW_STABLE, cnt 0, level_out 0,
//     rise_pulse 0, fall_pulse 0, stable 1, evt_count 0. All outputs registered.
//   - Synchronizer: raw_in shifted through SYNC_STAGES flops; last flop = sync_q.
//   - FSM states: LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW.
//     LOW_STABLE:  sync_q=1 -> if DEBOUNCE_CYCLES==1 commit rise, else LOW_TO_HIGH, cnt<=1.
//     LOW_TO_HIGH: sync_q=0 -> LOW_STABLE, cnt<=0 (glitch rejected, no pulse).
//                  sync_q=1 -> if cnt==DEBOUNCE_CYCLES-1 commit rise, else cnt<=cnt+1.
//     HIGH_STABLE / HIGH_TO_LOW: mirror image with sync_q inverted; commit fall.
//     Commit rise: state HIGH_STABLE, cnt<=0, level_out<=1, rise_pulse<=1 (next cycle 0).
//     Commit fall: state LOW_STABLE, cnt<=0, level_out<=0, fall_pulse<=1 (next cycle 0).
//   - Latency: raw_in step held steady -> level_out/pulse change at posedge
//     SYNC_STAGES+DEBOUNCE_CYCLES after the first edge sampling the new value.
//   - rise_pulse and fall_pulse never both 1; pulses are exactly one cycle.
//   - stable registered alongside state: 0 in LOW_TO_HIGH/HIGH_TO_LOW, else 1.
//   - evt_count: +1 on each cycle where commit rise occurs; saturates at 2^EVT_W-1 (no wrap).
//     clr_evt=1 -> evt_count<=0; clr_evt wins over a simultaneous increment (event dropped).
//   - Reset mid-debounce: partial count discarded, outputs to reset values immediately;
//     if raw_in stays high across reset, a full rise sequence (with rise_pulse) reoccurs.
//   - cnt never exceeds DEBOUNCE_CYCLES-1; no combinational path raw_in -> any output.
// STRUCTURE
//   - Shared package debounce_pkg: state encoding (2-bit localparams LOW_STABLE=0,
//     LOW_TO_HIGH=1, HIGH_STABLE=2, HIGH_TO_LOW=3), default DEBOUNCE_CYCLES/SYNC_STAGES.
//   - One sub-module: sync_ff (parameterized N-flop synchronizer, async active-high reset).
//   - FSM, debounce counter, pulse regs and event counter in this module.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EVT_W=8 unless noted)
//   1. Reset, raw_in 0->1 held -> level_out=1, rise_pulse=1 for one cycle at 6th posedge; evt_count=1.
//   2. raw_in high for 3 cycles then low -> level_out stays 0, no pulses, stable 0 then 1, evt_count=0.
//   3. From HIGH_STABLE, raw_in 1->0 held -> fall_pulse one cycle at 6th posedge, level_out=0, evt_count unchanged.
//   4. EVT_W=2: 5 clean rises -> evt_count=3; clr_evt asserted on commit-rise cycle -> evt_count=0.
//   5. Assert reset when LOW_TO_HIGH cnt=2 (raw_in high) -> outputs reset asynchronously; after release,
//      rise_pulse at 6th posedge.
//   6. DEBOUNCE_CYCLES=1: raw_in step -> level_out rises at 3rd posedge; 1-cycle raw glitch still commits.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and default parameters.
package debounce_pkg;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_EVT_W           = 8;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_TO_HIGH = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_TO_LOW = 2'd3
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for a single asynchronous bit; q is the last flop of the chain.
module sync_ff #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces one raw input, producing a clean level, edge pulses
// and a saturating count of committed rising edges.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned EVT_W           = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             clr_evt,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             stable,
  output logic [EVT_W-1:0] evt_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;

  logic             sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             stable_q, stable_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             commit_rise, commit_fall;

  sync_ff #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (sync_q)
  );

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    evt_d       = evt_q;
    commit_rise = 1'b0;
    commit_fall = 1'b0;

    case (state_q)
      LOW_STABLE: begin
        if (sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            commit_rise = 1'b1;
          end else begin
            state_d = LOW_TO_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOW_TO_HIGH: begin
        if (!sync_q) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit_rise = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH_STABLE: begin
        if (!sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            commit_fall = 1'b1;
          end else begin
            state_d = HIGH_TO_LOW;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      HIGH_TO_LOW: begin
        if (sync_q) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit_fall = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase

    if (commit_rise) begin
      state_d = HIGH_STABLE;
      cnt_d   = '0;
      level_d = 1'b1;
      rise_d  = 1'b1;
    end
    if (commit_fall) begin
      state_d = LOW_STABLE;
      cnt_d   = '0;
      level_d = 1'b0;
      fall_d  = 1'b1;
    end

    stable_d = (state_d == LOW_STABLE) || (state_d == HIGH_STABLE);

    // Clear has priority; a rise committed in the same cycle is dropped.
    if (clr_evt) begin
      evt_d = '0;
    end else if (commit_rise && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOW_STABLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stable_q <= 1'b1;
      evt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stable_q <= stable_d;
      evt_q    <= evt_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign stable     = stable_q;
  assign evt_count  = evt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: three instances cover the default depth,
// a narrow event counter and single-sample debounce.
module tb_input_debouncer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Instance A: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EVT_W=8
  logic       rst_a, raw_a, clr_a;
  logic       lvl_a, rise_a, fall_a, stb_a;
  logic [7:0] evt_a;
  // Instance B: EVT_W=2
  logic       rst_b, raw_b, clr_b;
  logic       lvl_b, rise_b, fall_b, stb_b;
  logic [1:0] evt_b;
  // Instance C: DEBOUNCE_CYCLES=1
  logic       rst_c, raw_c, clr_c;
  logic       lvl_c, rise_c, fall_c, stb_c;
  logic [7:0] evt_c;

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EVT_W(8)) dut_a (
    .clk(clk), .reset(rst_a), .raw_in(raw_a), .clr_evt(clr_a),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .stable(stb_a), .evt_count(evt_a)
  );

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EVT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .raw_in(raw_b), .clr_evt(clr_b),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .stable(stb_b), .evt_count(evt_b)
  );

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EVT_W(8)) dut_c (
    .clk(clk), .reset(rst_c), .raw_in(raw_c), .clr_evt(clr_c),
    .level_out(lvl_c), .rise_pulse(rise_c), .fall_pulse(fall_c),
    .stable(stb_c), .evt_count(evt_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; land 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full clean rise on instance B followed by a full clean fall.
  task automatic pulse_b();
    raw_b = 1'b1;
    tick(6);
    check("b_rise_pulse", 32'(rise_b), 32'd1);
    raw_b = 1'b0;
    tick(6);
    check("b_fall_level", 32'(lvl_b), 32'd0);
  endtask

  initial begin
    rst_a = 1'b1; raw_a = 1'b0; clr_a = 1'b0;
    rst_b = 1'b1; raw_b = 1'b0; clr_b = 1'b0;
    rst_c = 1'b1; raw_c = 1'b0; clr_c = 1'b0;
    tick(2);

    // Reset values
    check("rst_level",  32'(lvl_a),  32'd0);
    check("rst_rise",   32'(rise_a), 32'd0);
    check("rst_fall",   32'(fall_a), 32'd0);
    check("rst_stable", 32'(stb_a),  32'd1);
    check("rst_evt",    32'(evt_a),  32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick(2);

    // Glitch of 3 cycles is rejected
    raw_a = 1'b1;
    tick(3);
    check("glitch_stable_lo", 32'(stb_a), 32'd0);
    raw_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("glitch_level", 32'(lvl_a), 32'd0);
      check("glitch_rise",  32'(rise_a), 32'd0);
    end
    check("glitch_stable_hi", 32'(stb_a), 32'd1);
    check("glitch_evt",       32'(evt_a), 32'd0);
    tick(4);

    // Clean rise commits at the 6th edge
    raw_a = 1'b1;
    tick(5);
    check("rise_level_pre", 32'(lvl_a),  32'd0);
    check("rise_pulse_pre", 32'(rise_a), 32'd0);
    tick(1);
    check("rise_level",  32'(lvl_a),  32'd1);
    check("rise_pulse",  32'(rise_a), 32'd1);
    check("rise_fall",   32'(fall_a), 32'd0);
    check("rise_evt",    32'(evt_a),  32'd1);
    check("rise_stable", 32'(stb_a),  32'd1);
    tick(1);
    check("rise_pulse_end", 32'(rise_a), 32'd0);
    tick(3);

    // Clean fall commits at the 6th edge
    raw_a = 1'b0;
    tick(5);
    check("fall_level_pre", 32'(lvl_a),  32'd1);
    check("fall_pulse_pre", 32'(fall_a), 32'd0);
    tick(1);
    check("fall_level", 32'(lvl_a),  32'd0);
    check("fall_pulse", 32'(fall_a), 32'd1);
    check("fall_rise",  32'(rise_a), 32'd0);
    check("fall_evt",   32'(evt_a),  32'd1);
    tick(1);
    check("fall_pulse_end", 32'(fall_a), 32'd0);
    tick(3);

    // Reset mid-debounce is asynchronous and discards the partial count
    raw_a = 1'b1;
    tick(4);
    check("mid_stable", 32'(stb_a), 32'd0);
    rst_a = 1'b1;
    #1;
    check("async_stable", 32'(stb_a), 32'd1);
    check("async_evt",    32'(evt_a), 32'd0);
    tick(1);
    rst_a = 1'b0;
    tick(5);
    check("rerise_pre", 32'(rise_a), 32'd0);
    tick(1);
    check("rerise_pulse", 32'(rise_a), 32'd1);
    check("rerise_evt",   32'(evt_a),  32'd1);

    // Narrow counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      pulse_b();
      check("sat_evt", 32'(evt_b), (k < 3) ? 32'(k) : 32'd3);
    end

    // Clear on the commit-rise cycle wins over the increment
    raw_b = 1'b1;
    tick(5);
    clr_b = 1'b1;
    tick(1);
    clr_b = 1'b0;
    check("clr_rise", 32'(rise_b), 32'd1);
    check("clr_evt",  32'(evt_b),  32'd0);
    tick(1);
    check("clr_evt_hold", 32'(evt_b), 32'd0);

    // Single-sample debounce: commit at the 3rd edge
    raw_c = 1'b1;
    tick(2);
    check("dc1_level_pre", 32'(lvl_c), 32'd0);
    tick(1);
    check("dc1_level", 32'(lvl_c),  32'd1);
    check("dc1_rise",  32'(rise_c), 32'd1);
    raw_c = 1'b0;
    tick(3);
    check("dc1_fall",  32'(fall_c), 32'd1);
    check("dc1_level_lo", 32'(lvl_c), 32'd0);
    tick(2);

    // One-cycle raw glitch still commits with a single-sample debounce
    raw_c = 1'b1;
    tick(1);
    raw_c = 1'b0;
    tick(2);
    check("dc1_glitch_level", 32'(lvl_c),  32'd1);
    check("dc1_glitch_rise",  32'(rise_c), 32'd1);
    check("dc1_evt",          32'(evt_c),  32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
